// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Plain 2:1 multiplexer used to steer the winning requester's fields.
module mem_port_arbiter_mux2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded locking that shares one data-memory port between
// the load/store unit and a debug/DMA master, sequencing each transfer to completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  state_e            state_q;
  logic              owner_q;
  logic              lock_last_q;
  logic [CntW-1:0]   lock_cnt_q;
  logic [CntW-1:0]   lock_cnt_d;
  logic              winner;
  logic              grant;
  logic              sel_lock;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_comb begin
    winner     = owner_q;
    grant      = 1'b0;
    sel_lock   = 1'b0;
    lock_cnt_d = lock_cnt_q;

    if (req0 && !req1) begin
      winner = REQ_LSU;
    end else if (req1 && !req0) begin
      winner = REQ_DBG;
    end else if (lock_last_q && (lock_cnt_q < CntW'(MAX_LOCK))) begin
      winner = owner_q;
    end else begin
      winner = ~owner_q;
    end

    grant    = (state_q == StIdle) && (req0 || req1);
    sel_lock = (winner == REQ_DBG) ? lock1 : lock0;

    if (!sel_lock) begin
      lock_cnt_d = '0;
    end else if (winner != owner_q) begin
      lock_cnt_d = CntW'(1);
    end else if (lock_cnt_q < CntW'(MAX_LOCK)) begin
      lock_cnt_d = lock_cnt_q + CntW'(1);
    end
  end

  // Owner resets to the debug side so the LSU wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q     <= REQ_DBG;
      lock_last_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else if (grant) begin
      owner_q     <= winner;
      lock_last_q <= sel_lock;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  mem_port_arbiter_mux2 #(
    .WIDTH(ADDR_W)
  ) u_mux_addr (
    .a_i  (addr0),
    .b_i  (addr1),
    .sel_i(winner),
    .y_o  (sel_addr)
  );

  mem_port_arbiter_mux2 #(
    .WIDTH(DATA_W)
  ) u_mux_wdata (
    .a_i  (wdata0),
    .b_i  (wdata1),
    .sel_i(winner),
    .y_o  (sel_wdata)
  );

  mem_port_arbiter_mux2 #(
    .WIDTH(1)
  ) u_mux_we (
    .a_i  (we0),
    .b_i  (we1),
    .sel_i(winner),
    .y_o  (sel_we)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
            done0_q <= (owner_q == REQ_LSU);
            done1_q <= (owner_q == REQ_DBG);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0      = grant && (winner == REQ_LSU);
  assign gnt1      = grant && (winner == REQ_DBG);
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned ML = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_req[2];
  logic        r_lock[2];
  logic        r_we[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        owner;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 1;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] dut_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  int exp_rr[6]   = '{0, 1, 0, 1, 0, 1};
  int exp_lock[5] = '{0, 0, 0, 1, 0};
  int gseq[$];

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_LOCK(ML)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (r_req[0]),
    .req1     (r_req[1]),
    .lock0    (r_lock[0]),
    .lock1    (r_lock[1]),
    .we0      (r_we[0]),
    .we1      (r_we[1]),
    .addr0    (r_addr[0]),
    .addr1    (r_addr[1]),
    .wdata0   (r_wdata[0]),
    .wdata1   (r_wdata[1]),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .owner    (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] rd_dut(input logic [31:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory responder: stalls per rdy_mode, returns contents of the addressed word.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && mem_ready && mem_we) dut_mem[mem_addr] = mem_wdata;
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       mem_ready = ($urandom_range(0, 2) != 0);
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'b0;
      endcase
      mem_rdata = rd_dut(mem_addr);
    end
  end

  // Reference model: who should win, what the port should carry, what completes when.
  initial begin
    bit          busy_m = 1'b0;
    logic        owner_m = 1'b1;
    logic        lock_last_m = 1'b0;
    int          cnt_m = 0;
    logic        cur_who = 1'b0;
    logic        cur_we = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [31:0] rdata_m = '0;
    logic [31:0] rv;
    logic        w, lk;
    bit          any;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_m      = 1'b0;
        owner_m     = 1'b1;
        lock_last_m = 1'b0;
        cnt_m       = 0;
        rdata_m     = '0;
        exp_q.delete();
      end else if (chk_en) begin
        check("owner", owner, owner_m);
        check("mem_req", mem_req, busy_m);
        if (busy_m) begin
          check("mem_we", mem_we, cur_we);
          check("mem_addr", mem_addr, cur_addr);
          check("mem_wdata", mem_wdata, cur_wdata);
          check("gnt_while_busy", {gnt1, gnt0}, 0);
          if (mem_ready) begin
            rv = cur_we ? rdata_m : rd_ref(cur_addr);
            if (cur_we) ref_mem[cur_addr] = cur_wdata;
            rdata_m = rv;
            exp_q.push_back('{who: cur_who, rdata: rv, c: cyc + 1});
            busy_m = 1'b0;
          end
        end else begin
          any = r_req[0] || r_req[1];
          if (r_req[0] && !r_req[1]) w = 1'b0;
          else if (r_req[1] && !r_req[0]) w = 1'b1;
          else if (lock_last_m && cnt_m < ML) w = owner_m;
          else w = !owner_m;
          check("gnt0", gnt0, any && !w);
          check("gnt1", gnt1, any && w);
          if (any) begin
            lk = r_lock[w];
            if (!lk) cnt_m = 0;
            else if (w != owner_m) cnt_m = 1;
            else if (cnt_m < ML) cnt_m = cnt_m + 1;
            lock_last_m = lk;
            owner_m     = w;
            cur_who     = w;
            cur_we      = r_we[w];
            cur_addr    = r_addr[w];
            cur_wdata   = r_wdata[w];
            busy_m      = 1'b1;
          end
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        if (done0 || done1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: got done=%b%b expected none (cycle %0d)",
                     done1, done0, cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_who", {done1, done0}, e.who ? 2'b10 : 2'b01);
            check("rdata", rdata, e.rdata);
            check("done_cycle", cyc, e.c);
          end
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          checks++;
          failures++;
          $display("FAIL done_missing: got no done expected done at cycle %0d", exp_q[0].c);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int id, input logic lk, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    r_lock[id]  = lk;
    r_we[id]    = we;
    r_addr[id]  = a;
    r_wdata[id] = d;
    r_req[id]   = 1'b1;
  endtask

  task automatic collect_grants(input int n);
    gseq.delete();
    for (int i = 0; i < 60 && gseq.size() < n; i++) begin
      @(negedge clk);
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
    end
    check("grant_count", gseq.size(), n);
  endtask

  task automatic run_req(input int id, input int n);
    int waitc;
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      set_req(id, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 15)) << 2, $urandom);
      got   = 1'b0;
      waitc = 0;
      while (!got && waitc < 200) begin
        @(negedge clk);
        if (id == 0 ? gnt0 : gnt1) got = 1'b1;
        else if ($urandom_range(0, 15) == 0) break;
        waitc++;
      end
      if (!got && waitc >= 200) begin
        checks++;
        failures++;
        $display("FAIL grant_timeout: got no gnt%0d expected gnt within 200 cycles", id);
      end
      @(posedge clk);
      #1;
      r_req[id] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_req[i]   = 1'b0;
      r_lock[i]  = 1'b0;
      r_we[i]    = 1'b0;
      r_addr[i]  = '0;
      r_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_owner", owner, 1);

    // Single read, minimum latency.
    dut_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    rdy_mode = 1;
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check("t1_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    r_req[0] = 1'b0;
    @(negedge clk);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    @(negedge clk);
    check("t1_done0", done0, 1);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);

    // Continuous unlocked contention alternates.
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h20, 32'h0);
    collect_grants(6);
    for (int i = 0; i < gseq.size(); i++) check("rr_order", gseq[i], exp_rr[i]);
    @(posedge clk);
    #1;
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    idle_cycles(4);

    // Locked requester 0 keeps the port for ML grants, then must yield.
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h20, 32'h0);
    collect_grants(5);
    for (int i = 0; i < gseq.size(); i++) check("lock_order", gseq[i], exp_lock[i]);
    @(posedge clk);
    #1;
    r_req[0]  = 1'b0;
    r_req[1]  = 1'b0;
    r_lock[0] = 1'b0;
    idle_cycles(4);

    // Write with a stalling memory.
    rdy_mode = 2;
    do_reset();
    set_req(1, 1'b0, 1'b1, 32'h40, 32'h1234);
    @(negedge clk);
    check("t4_gnt1", gnt1, 1);
    @(posedge clk);
    #1;
    r_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_mem_req", mem_req, 1);
      check("t4_mem_we", mem_we, 1);
      check("t4_mem_addr", mem_addr, 32'h40);
      check("t4_mem_wdata", mem_wdata, 32'h1234);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    @(negedge clk);
    check("t4_no_early_done", done1, 0);
    @(negedge clk);
    check("t4_done1", done1, 1);
    check("t4_rdata_kept", rdata, 0);

    // Reset in the middle of an access abandons it.
    rdy_mode = 2;
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    check("t5_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    r_req[0] = 1'b0;
    @(negedge clk);
    check("t5_mem_req_busy", mem_req, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_mem_req_after", mem_req, 0);
    check("t5_no_done", {done1, done0}, 0);
    check("t5_owner", owner, 1);
    idle_cycles(2);

    // A late request waits for the port to go idle.
    do_reset();
    set_req(0, 1'b0, 1'b0, 32'hC, 32'h0);
    @(negedge clk);
    check("t6_gnt0", gnt0, 1);
    @(posedge clk);
    #1;
    r_req[0] = 1'b0;
    set_req(1, 1'b0, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_gnt1_held", gnt1, 0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    @(negedge clk);
    check("t6_gnt1_ready_cycle", gnt1, 0);
    @(negedge clk);
    check("t6_done0", done0, 1);
    check("t6_gnt1", gnt1, 1);
    @(posedge clk);
    #1;
    r_req[1] = 1'b0;
    idle_cycles(4);

    // Randomized traffic from both requesters with random stalls.
    do_reset();
    rdy_mode = 0;
    fork
      run_req(0, 60);
      run_req(1, 60);
    join
    rdy_mode = 1;
    idle_cycles(10);
    check("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
